// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 (double-dabble) binary-to-BCD converter.
// One input bit is consumed per clock while busy is high. The result is
// registered and held until the next conversion completes. Anything at or
// above 10^D wraps modulo 10^D and raises overflow.
module bin2bcd_seq #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     bin,
  output logic             busy,
  output logic             done,
  output logic [4*D-1:0]   bcd,
  output logic             overflow
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     shift_reg, shift_next;
  logic [4*D-1:0]   acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             ovf_acc_reg, ovf_acc_next;
  logic [4*D-1:0]   bcd_reg, bcd_next;
  logic             overflow_reg, overflow_next;
  logic             done_reg, done_next;

  // Per-digit +3 correction, applied before each shift. There is no carry
  // between digits: a corrected digit never exceeds 4'hC.
  logic [4*D-1:0]   acc_corr;
  logic [4*D-1:0]   acc_shift;
  logic             ovf_step;

  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_digit
      assign acc_corr[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                   acc_reg[4*gi +: 4] + 4'd3 :
                                   acc_reg[4*gi +: 4];
    end
  endgenerate

  // Shift the corrected accumulator left and bring in the next binary MSB.
  // The bit leaving the top digit is worth 10^D, so it feeds the sticky
  // overflow flag.
  assign acc_shift = {acc_corr[4*D-2:0], shift_reg[W-1]};
  assign ovf_step  = ovf_acc_reg | acc_corr[4*D-1];

  // Next-state and datapath control. Every register holds unless updated.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    ovf_acc_next  = ovf_acc_reg;
    bcd_next      = bcd_reg;
    overflow_next = overflow_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next   = bin;
          acc_next     = '0;
          ovf_acc_next = 1'b0;
          cnt_next     = CW'(W);
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        shift_next   = shift_reg << 1;
        acc_next     = acc_shift;
        ovf_acc_next = ovf_step;
        cnt_next     = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          bcd_next      = acc_shift;
          overflow_next = ovf_step;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers. Reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_acc_reg  <= 1'b0;
      bcd_reg      <= '0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      ovf_acc_reg  <= ovf_acc_next;
      bcd_reg      <= bcd_next;
      overflow_reg <= overflow_next;
      done_reg     <= done_next;
    end
  end

  assign busy     = (state_reg == SHIFT);
  assign done     = done_reg;
  assign bcd      = bcd_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq. It uses the default W=8, D=3 instance and
// a W=10, D=3 instance to exercise the overflow cases.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start8, busy8, done8, ovf8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;
  logic        start10, busy10, done10, ovf10;
  logic [9:0]  bin10;
  logic [11:0] bcd10;

  int checks = 0;
  int failures = 0;

  bin2bcd_seq #(.W(8), .D(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8)
  );

  bin2bcd_seq #(.W(10), .D(3)) dut10 (
    .clk(clk), .reset(reset), .start(start10), .bin(bin10),
    .busy(busy10), .done(done10), .bcd(bcd10), .overflow(ovf10)
  );

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one conversion and check busy length, the done pulse, the result and the hold.
  task automatic run_conv(input bit wide, input logic [9:0] value,
                          input logic [11:0] exp_bcd, input logic exp_ovf,
                          input string name);
    int busy_n;
    int guard;
    int exp_w;
    logic b, d, o;
    logic [11:0] r;
    exp_w = wide ? 10 : 8;
    if (wide) begin start10 = 1'b1; bin10 = value; end
    else      begin start8 = 1'b1;  bin8 = value[7:0]; end
    step();
    start8 = 1'b0; start10 = 1'b0;
    bin8 = 8'hA5; bin10 = 10'h2AA;
    busy_n = 0;
    guard = 0;
    d = 1'b0;
    b = 1'b0;
    while (guard < 40) begin
      b = wide ? busy10 : busy8;
      d = wide ? done10 : done8;
      if (d) break;
      if (b) busy_n++;
      guard++;
      step();
    end
    checks++;
    if (d !== 1'b1) begin
      failures++;
      $display("FAIL %s done_timeout got_done=%b exp=1", name, d);
    end
    checks++;
    if (busy_n != exp_w || b !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d busy_at_done=%b", name, busy_n, exp_w, b);
    end
    r = wide ? bcd10 : bcd8;
    o = wide ? ovf10 : ovf8;
    checks++;
    if (r !== exp_bcd || o !== exp_ovf) begin
      failures++;
      $display("FAIL %s result got=%h/%b exp=%h/%b", name, r, o, exp_bcd, exp_ovf);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      d = wide ? done10 : done8;
      r = wide ? bcd10 : bcd8;
      o = wide ? ovf10 : ovf8;
      checks++;
      if (d !== 1'b0 || r !== exp_bcd || o !== exp_ovf) begin
        failures++;
        $display("FAIL %s hold%0d got done=%b bcd=%h ovf=%b exp done=0 bcd=%h ovf=%b",
                 name, k, d, r, o, exp_bcd, exp_ovf);
      end
    end
    $display("conv %s bin=%0d bcd=%h ovf=%b busy_cycles=%0d", name, value, r, o, busy_n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 12'h000 || ovf8 !== 1'b0 ||
        busy10 !== 1'b0 || done10 !== 1'b0 || bcd10 !== 12'h000 || ovf10 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b bcd=%h ovf=%b / busy=%b done=%b bcd=%h ovf=%b exp all zero",
               busy8, done8, bcd8, ovf8, busy10, done10, bcd10, ovf10);
    end
    reset = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_basic();
    run_conv(1'b0, 10'd255, 12'h255, 1'b0, "b255");
    run_conv(1'b0, 10'd0,   12'h000, 1'b0, "b0");
    run_conv(1'b0, 10'd99,  12'h099, 1'b0, "b99");
    run_conv(1'b0, 10'd100, 12'h100, 1'b0, "b100");
    run_conv(1'b0, 10'd9,   12'h009, 1'b0, "b9");
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 256; v++)
      run_conv(1'b0, 10'(v), ref_bcd(v), 1'b0, "exh");
  endtask

  task automatic test_start_while_busy();
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    logic [11:0] res = 12'hFFF;
    start8 = 1'b1; bin8 = 8'd200;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (done_at < 0) done_at = i;
        res = bcd8;
      end
      if (i == 3) begin start8 = 1'b1; bin8 = 8'd17; end
      else start8 = 1'b0;
      step();
    end
    checks++;
    if (busy_n != 8 || done_n != 1 || done_at != 8) begin
      failures++;
      $display("FAIL swb_timing got busy=%0d dones=%0d done_at=%0d exp busy=8 dones=1 done_at=8",
               busy_n, done_n, done_at);
    end
    checks++;
    if (res !== 12'h200) begin
      failures++;
      $display("FAIL swb_result got=%h exp=200", res);
    end
    $display("start_while_busy bcd=%h dones=%0d busy=%0d", res, done_n, busy_n);
  endtask

  task automatic test_back_to_back();
    int done_n = 0;
    int at1 = -1;
    int at2 = -1;
    logic [11:0] r1 = 12'hFFF;
    logic [11:0] r2 = 12'hFFF;
    logic busy_restart = 1'b0;
    start8 = 1'b1; bin8 = 8'd42;
    step();
    bin8 = 8'd7;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin
        done_n++;
        if (at1 < 0) begin at1 = i; r1 = bcd8; end
        else if (at2 < 0) begin at2 = i; r2 = bcd8; end
      end
      if (i == 9) busy_restart = busy8;
      if (i >= 9) start8 = 1'b0;
      step();
    end
    checks++;
    if (done_n != 2 || at1 != 8 || at2 != 17 || busy_restart !== 1'b1) begin
      failures++;
      $display("FAIL b2b_timing got dones=%0d at=%0d,%0d restart=%b exp dones=2 at=8,17 restart=1",
               done_n, at1, at2, busy_restart);
    end
    checks++;
    if (r1 !== 12'h042 || r2 !== 12'h007) begin
      failures++;
      $display("FAIL b2b_result got=%h,%h exp=042,007", r1, r2);
    end
    $display("back_to_back bcd=%h,%h spacing=%0d", r1, r2, at2 - at1);
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    start8 = 1'b1; bin8 = 8'd255;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done8) done_n++;
      if (i == 4) begin
        checks++;
        if (busy8 !== 1'b0 || bcd8 !== 12'h000 || ovf8 !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid_state got busy=%b bcd=%h ovf=%b exp 0/000/0", busy8, bcd8, ovf8);
        end
      end
      reset = (i == 3);
      step();
    end
    reset = 1'b0;
    checks++;
    if (done_n != 0) begin
      failures++;
      $display("FAIL rst_mid_done got=%0d exp=0", done_n);
    end
    $display("reset_mid dones=%0d", done_n);
    run_conv(1'b0, 10'd128, 12'h128, 1'b0, "after_rst");
  endtask

  task automatic test_overflow();
    run_conv(1'b1, 10'd1023, 12'h023, 1'b1, "w10_1023");
    run_conv(1'b1, 10'd999,  12'h999, 1'b0, "w10_999");
    run_conv(1'b1, 10'd1000, 12'h000, 1'b1, "w10_1000");
    run_conv(1'b1, 10'd512,  12'h512, 1'b0, "w10_512");
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0; bin8 = '0;
    start10 = 1'b0; bin10 = '0;
    test_reset();
    test_basic();
    test_exhaustive();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
